// File: rtl/brick_sequencer_if.sv
// Interface between the brick sequencer and the joystick/column controller.
// The sequencer takes the slave modport, the controller (or bench) the master modport.
interface brick_sequencer_if #(
    parameter int unsigned SCORE_W = 8
) ();
    logic               start;
    logic               fast_drop;
    logic [1:0]         col;
    logic [2:0]         row;
    logic [2:0]         hauteurGauche;
    logic [2:0]         hauteurCentre;
    logic [2:0]         hauteurDroite;
    logic               spawn;
    logic               brick_active;
    logic               game_over;
    logic [SCORE_W-1:0] score;

    modport master (
        output start, fast_drop, col,
        input  row, hauteurGauche, hauteurCentre, hauteurDroite,
        input  spawn, brick_active, game_over, score
    );

    modport slave (
        input  start, fast_drop, col,
        output row, hauteurGauche, hauteurCentre, hauteurDroite,
        output spawn, brick_active, game_over, score
    );
endinterface

// File: rtl/brick_sequencer.sv
// Three-column brick game sequencer: spawns bricks, paces their fall, lands them on the
// stack under the chosen column, keeps the stack heights and score, flags game over.
// Optional feature macro: LINE_CLEAR_EN (full bottom row is removed in CHECK and the
// score then counts cleared lines instead of landed bricks).
module brick_sequencer #(
    parameter int unsigned DROP_DIV   = 50_000_000,
    parameter int unsigned FAST_DIV   = 5_000_000,
    parameter int unsigned TOP_ROW    = 7,
    parameter int unsigned MAX_HEIGHT = 7,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    brick_sequencer_if.slave   bus
);
    localparam int unsigned DIV_W = $clog2(DROP_DIV);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SPAWN     = 3'd1;
    localparam logic [2:0] S_FALL      = 3'd2;
    localparam logic [2:0] S_LAND      = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;

    localparam logic [2:0]       TOP_R   = 3'(TOP_ROW);
    localparam logic [2:0]       MAX_H   = 3'(MAX_HEIGHT);
    localparam logic [DIV_W-1:0] DROP_M1 = DIV_W'(DROP_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_M1 = DIV_W'(FAST_DIV - 1);

    logic [2:0]         r_state;
    logic [2:0]         r_row;
    logic [2:0]         r_h_l, r_h_c, r_h_r;
    logic [SCORE_W-1:0] r_score;
    logic [DIV_W-1:0]   r_div;
    logic               r_spawn, r_brick_active, r_game_over;

    logic [2:0]       w_state_d;
    logic [1:0]       w_col;
    logic [2:0]       w_h_sel;
    logic [2:0]       w_h_inc;
    logic [DIV_W-1:0] w_div_lim;
    logic             w_tick;
    logic             w_hit;
    logic             w_clear;
    logic [2:0]       w_h_l_chk, w_h_c_chk, w_h_r_chk;
    logic             w_over;

    // Column decode, selected stack height, fall pacing and post-clear heights.
    always_comb begin
        w_col     = (bus.col == 2'd3) ? 2'd1 : bus.col;
        w_h_sel   = (w_col == 2'd0) ? r_h_l : (w_col == 2'd2) ? r_h_r : r_h_c;
        w_h_inc   = (w_h_sel == 3'd7) ? 3'd7 : w_h_sel + 3'd1;
        w_div_lim = bus.fast_drop ? FAST_M1 : DROP_M1;
        // >= so a switch to the shorter period mid-count ticks at once
        w_tick    = (r_div >= w_div_lim);
        w_hit     = (r_row <= w_h_sel);
`ifdef LINE_CLEAR_EN
        w_clear   = (r_h_l != 3'd0) && (r_h_c != 3'd0) && (r_h_r != 3'd0);
`else
        w_clear   = 1'b0;
`endif
        w_h_l_chk = w_clear ? r_h_l - 3'd1 : r_h_l;
        w_h_c_chk = w_clear ? r_h_c - 3'd1 : r_h_c;
        w_h_r_chk = w_clear ? r_h_r - 3'd1 : r_h_r;
        w_over    = (w_h_l_chk >= MAX_H) || (w_h_c_chk >= MAX_H) || (w_h_r_chk >= MAX_H);
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:      if (bus.start) w_state_d = S_SPAWN;
            S_SPAWN:     w_state_d = S_FALL;
            S_FALL:      if (w_tick && w_hit) w_state_d = S_LAND;
            S_LAND:      w_state_d = S_CHECK;
            S_CHECK:     w_state_d = w_over ? S_GAME_OVER : S_SPAWN;
            S_GAME_OVER: if (bus.start) w_state_d = S_SPAWN;
            default:     w_state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_row          <= TOP_R;
            r_h_l          <= 3'd0;
            r_h_c          <= 3'd0;
            r_h_r          <= 3'd0;
            r_score        <= '0;
            r_div          <= '0;
            r_spawn        <= 1'b0;
            r_brick_active <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_spawn        <= (w_state_d == S_SPAWN);
            r_brick_active <= (w_state_d == S_FALL);
            r_game_over    <= (w_state_d == S_GAME_OVER);
            case (r_state)
                S_SPAWN: begin
                    r_row <= TOP_R;
                    r_div <= '0;
                end
                S_FALL: begin
                    if (w_tick) begin
                        r_div <= '0;
                        // row stays put on the landing tick
                        if (!w_hit) r_row <= r_row - 3'd1;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_LAND: begin
                    case (w_col)
                        2'd0:    r_h_l <= w_h_inc;
                        2'd2:    r_h_r <= w_h_inc;
                        default: r_h_c <= w_h_inc;
                    endcase
`ifndef LINE_CLEAR_EN
                    r_score <= r_score + SCORE_W'(1);
`endif
                end
                S_CHECK: begin
                    r_h_l <= w_h_l_chk;
                    r_h_c <= w_h_c_chk;
                    r_h_r <= w_h_r_chk;
                    if (w_clear) r_score <= r_score + SCORE_W'(1);
                end
                S_GAME_OVER: begin
                    if (bus.start) begin
                        r_h_l   <= 3'd0;
                        r_h_c   <= 3'd0;
                        r_h_r   <= 3'd0;
                        r_score <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.row           = r_row;
    assign bus.hauteurGauche = r_h_l;
    assign bus.hauteurCentre = r_h_c;
    assign bus.hauteurDroite = r_h_r;
    assign bus.score         = r_score;
    assign bus.spawn         = r_spawn;
    assign bus.brick_active  = r_brick_active;
    assign bus.game_over     = r_game_over;
endmodule

// File: tb/tb_brick_sequencer.sv
// Self-checking bench for brick_sequencer with a scoreboard of expected heights/score.
module tb_brick_sequencer;
    localparam int DROP_DIV   = 4;
    localparam int FAST_DIV   = 2;
    localparam int TOP_ROW    = 7;
    localparam int MAX_HEIGHT = 7;
    localparam int SCORE_W    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    brick_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

    brick_sequencer #(
        .DROP_DIV  (DROP_DIV),
        .FAST_DIV  (FAST_DIV),
        .TOP_ROW   (TOP_ROW),
        .MAX_HEIGHT(MAX_HEIGHT),
        .SCORE_W   (SCORE_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // {game_over, left, centre, right, score}
    logic [17:0] sb_q[$];
    int m_h[3];
    int m_score;

    function automatic logic [17:0] obs();
        return {bus.game_over, bus.hauteurGauche, bus.hauteurCentre, bus.hauteurDroite, bus.score};
    endfunction

    function automatic logic [17:0] model_brick(input logic [1:0] c);
        int  k;
        logic go;
        k = (c == 2'd3) ? 1 : int'(c);
        if (m_h[k] < 7) m_h[k] = m_h[k] + 1;
`ifdef LINE_CLEAR_EN
        if (m_h[0] >= 1 && m_h[1] >= 1 && m_h[2] >= 1) begin
            for (int i = 0; i < 3; i++) m_h[i] = m_h[i] - 1;
            m_score = m_score + 1;
        end
`else
        m_score = m_score + 1;
`endif
        go = (m_h[0] >= MAX_HEIGHT) || (m_h[1] >= MAX_HEIGHT) || (m_h[2] >= MAX_HEIGHT);
        return {go, 3'(m_h[0]), 3'(m_h[1]), 3'(m_h[2]), 8'(m_score)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_h[i] = 0;
        m_score = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.fast_drop = 1'b0; bus.col = 2'd1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Leaves the bench on the negedge where the SPAWN pulse is visible.
    task automatic start_game();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic launch(input logic [1:0] c, input logic f);
        bus.col = c;
        bus.fast_drop = f;
        sb_q.push_back(model_brick(c));
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.spawn || bus.game_over) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.row !== 3'd7) begin
            n_err++; $display("FAIL reset_row: got %0d expected 7", bus.row);
        end
        n_checks++;
        if (obs() !== 18'h0) begin
            n_err++; $display("FAIL reset_state: got %h expected 0", obs());
        end
        n_checks++;
        if ({bus.spawn, bus.brick_active} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00", {bus.spawn, bus.brick_active});
        end
    endtask

    task automatic test_normal_fall();
        logic [17:0] exp;
        bit ok;
        start_game();
        n_checks++;
        if ({bus.spawn, bus.row} !== {1'b1, 3'd7}) begin
            n_err++; $display("FAIL first_spawn: got %b expected 1111", {bus.spawn, bus.row});
        end
        launch(2'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < DROP_DIV; j++) begin
                @(negedge clk);
                n_checks++;
                if ({bus.brick_active, bus.row} !== {1'b1, 3'(7 - i)}) begin
                    n_err++;
                    $display("FAIL normal_row: got %b expected %b",
                             {bus.brick_active, bus.row}, {1'b1, 3'(7 - i)});
                end
            end
        end
        wait_done(ok);
        n_checks++;
        if (!ok || bus.spawn !== 1'b1) begin
            n_err++; $display("FAIL normal_respawn: got %b expected 1", bus.spawn);
        end
        exp = sb_q.pop_front();
        n_checks++;
        if (obs() !== exp) begin
            n_err++; $display("FAIL normal_land: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_fast_drop();
        logic [17:0] exp;
        bit ok;
        launch(2'd2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < FAST_DIV; j++) begin
                @(negedge clk);
                n_checks++;
                if (bus.row !== 3'(7 - i)) begin
                    n_err++; $display("FAIL fast_row: got %0d expected %0d", bus.row, 7 - i);
                end
            end
        end
        wait_done(ok);
        exp = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== exp) begin
            n_err++; $display("FAIL fast_land: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_stack_land();
        logic [17:0] exp;
        bit ok;
        bit seen;
        launch(2'd1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (!bus.brick_active) seen = 1'b1;
        end
        n_checks++;
        if (!seen || bus.row !== 3'd1) begin
            n_err++; $display("FAIL stack_land_row: got %0d expected 1", bus.row);
        end
        wait_done(ok);
        exp = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== exp || bus.hauteurCentre !== 3'd2) begin
            n_err++; $display("FAIL stack_land: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_game_over();
        logic [17:0] exp;
        bit ok;
        do_reset();
        start_game();
        for (int b = 0; b < 7; b++) begin
            launch(2'd0, 1'b1);
            wait_done(ok);
            exp = sb_q.pop_front();
            n_checks++;
            if (!ok || obs() !== exp) begin
                n_err++; $display("FAIL col0_brick%0d: got %h expected %h", b, obs(), exp);
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.game_over, bus.brick_active, bus.spawn, bus.hauteurGauche} !== {3'b100, 3'd7}) begin
            n_err++;
            $display("FAIL game_over_hold: got %b expected 100111",
                     {bus.game_over, bus.brick_active, bus.spawn, bus.hauteurGauche});
        end
        start_game();
        model_reset();
        n_checks++;
        if ({bus.spawn, obs()} !== {1'b1, 18'h0}) begin
            n_err++; $display("FAIL restart: got %h expected %h", {bus.spawn, obs()}, {1'b1, 18'h0});
        end
    endtask

    task automatic test_reset_mid_fall();
        logic [17:0] exp;
        bit ok;
        bit seen;
        bit spurious;
        launch(2'd2, 1'b1);
        wait_done(ok);
        exp = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== exp) begin
            n_err++; $display("FAIL pre_reset_land: got %h expected %h", obs(), exp);
        end
        launch(2'd0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.row == 3'd3) seen = 1'b1;
        end
        n_checks++;
        if (!seen || bus.brick_active !== 1'b1) begin
            n_err++; $display("FAIL reach_row3: got %0d expected 3", bus.row);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.row, obs()} !== {3'd7, 18'h0}) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", {bus.row, obs()}, {3'd7, 18'h0});
        end
        n_checks++;
        if ({bus.spawn, bus.brick_active, bus.game_over} !== 3'b000) begin
            n_err++; $display("FAIL async_reset_flags: got %b expected 000",
                              {bus.spawn, bus.brick_active, bus.game_over});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        spurious = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.spawn || bus.brick_active || bus.row != 3'd7) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin
            n_err++; $display("FAIL idle_after_reset: got activity expected none");
        end
    endtask

    task automatic test_clear_sequence();
        logic [17:0] exp;
        logic [17:0] fixed_exp;
        logic [1:0]  cols [3];
        bit ok;
        cols[0] = 2'd0; cols[1] = 2'd3; cols[2] = 2'd2;
        start_game();
        n_checks++;
        if (bus.spawn !== 1'b1) begin
            n_err++; $display("FAIL start_from_idle: got %b expected 1", bus.spawn);
        end
        for (int b = 0; b < 3; b++) begin
            launch(cols[b], 1'b1);
            wait_done(ok);
            exp = sb_q.pop_front();
            n_checks++;
            if (!ok || obs() !== exp) begin
                n_err++; $display("FAIL clear_seq%0d: got %h expected %h", b, obs(), exp);
            end
        end
`ifdef LINE_CLEAR_EN
        fixed_exp = {1'b0, 3'd0, 3'd0, 3'd0, 8'd1};
`else
        fixed_exp = {1'b0, 3'd1, 3'd1, 3'd1, 8'd3};
`endif
        n_checks++;
        if (obs() !== fixed_exp) begin
            n_err++; $display("FAIL clear_final: got %h expected %h", obs(), fixed_exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.fast_drop = 1'b0;
        bus.col = 2'd1;
        test_reset();
        test_normal_fall();
        test_fast_drop();
        test_stack_land();
        test_game_over();
        test_reset_mid_fall();
        test_clear_sequence();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
